// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter (ALU / load unit) into a single register-file write port,
// with round-robin tie-break and a 32-entry pending-write scoreboard for hazard checks.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_addr,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} arb_state_e;

  arb_state_e      state, state_nxt;
  logic            grant_a, grant_b;
  logic            hs;
  logic [4:0]      hs_addr;
  logic [XLEN-1:0] hs_data;
  logic [31:0]     busy, busy_nxt;

  // Arbiter state register; LAST_B out of reset so the first tie goes to A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LAST_B;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (grant_a)      state_nxt = LAST_A;
    else if (grant_b) state_nxt = LAST_B;
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        grant_a = (state == LAST_B);
        grant_b = (state == LAST_A);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign hs      = grant_a | grant_b;
  assign hs_addr = grant_a ? a_addr : b_addr;
  assign hs_data = grant_a ? a_data : b_data;

  // One-cycle registered write port; x0 handshakes complete but never raise rf_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= hs && (hs_addr != 5'd0);
      if (hs) begin
        rf_waddr <= hs_addr;
        rf_wdata <= hs_data;
      end
    end
  end

  // Clear is applied before set so an issue to the same register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (hs && hs_addr != 5'd0)          busy_nxt[hs_addr]  = 1'b0;
    if (iss_valid && iss_addr != 5'd0)  busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write latency, x0 drop,
// scoreboard set/clear priority and asynchronous reset behaviour.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, b_valid, iss_valid;
  logic [4:0]      a_addr, b_addr, iss_addr, rs1_addr, rs2_addr;
  logic [XLEN-1:0] a_data, b_data;
  logic            a_ready, b_ready, rs1_busy, rs2_busy, rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; iss_valid = 0;
    a_addr = 0; b_addr = 0; iss_addr = 0; rs1_addr = 0; rs2_addr = 0;
    a_data = 0; b_data = 0;

    // Reset state
    #3;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    a_valid = 1; b_valid = 1;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    step(); step();
    rst = 1'b0;

    // Tie after reset: A, then B, one-cycle write latency
    a_addr = 5; a_data = 32'h11; b_addr = 6; b_data = 32'h22;
    #1;
    chk("tie0_a_ready", a_ready, 1);
    chk("tie0_b_ready", b_ready, 0);
    step();
    chk("tie1_we", rf_we, 1);
    chk("tie1_waddr", rf_waddr, 5);
    chk("tie1_wdata", rf_wdata, 32'h11);
    chk("tie1_a_ready", a_ready, 0);
    chk("tie1_b_ready", b_ready, 1);
    step();
    chk("tie2_we", rf_we, 1);
    chk("tie2_waddr", rf_waddr, 6);
    chk("tie2_wdata", rf_wdata, 32'h22);
    a_valid = 0; b_valid = 0;
    #1;
    chk("idle_a_ready", a_ready, 0);
    step();
    chk("idle_we", rf_we, 0);
    chk("idle_waddr_hold", rf_waddr, 6);
    chk("idle_wdata_hold", rf_wdata, 32'h22);

    // Scoreboard set on issue, clear on writeback, no bypass
    iss_valid = 1; iss_addr = 7; rs1_addr = 7;
    #1;
    chk("sb_no_bypass", rs1_busy, 0);
    step();
    iss_valid = 0;
    chk("sb_set7", rs1_busy, 1);
    a_valid = 1; a_addr = 7; a_data = 32'h77;
    #1;
    chk("sb_a_ready", a_ready, 1);
    chk("sb_busy_same_cycle", rs1_busy, 1);
    step();
    a_valid = 0;
    chk("sb_clr7", rs1_busy, 0);
    chk("sb_we", rf_we, 1);
    chk("sb_waddr", rf_waddr, 7);

    // x0 write accepted but dropped; x0 never busy
    a_valid = 1; a_addr = 0; a_data = 32'hFF;
    iss_valid = 1; iss_addr = 0; rs2_addr = 0;
    #1;
    chk("x0_a_ready", a_ready, 1);
    step();
    a_valid = 0; iss_valid = 0;
    chk("x0_we", rf_we, 0);
    chk("x0_busy", rs2_busy, 0);

    // Set wins over clear on the same address; clear of a non-busy reg is ignored
    iss_valid = 1; iss_addr = 9; rs1_addr = 9;
    step();
    chk("sw_pre9", rs1_busy, 1);
    b_valid = 1; b_addr = 9; b_data = 32'h99;
    #1;
    chk("sw_b_ready", b_ready, 1);
    step();
    iss_valid = 0; b_valid = 0;
    chk("sw_busy9", rs1_busy, 1);
    chk("sw_we", rf_we, 1);
    chk("sw_wdata", rf_wdata, 32'h99);
    rs2_addr = 12;
    a_valid = 1; a_addr = 12; a_data = 32'hC;
    step();
    a_valid = 0;
    chk("clr_nonbusy12", rs2_busy, 0);
    chk("clr_nonbusy_keep9", rs1_busy, 1);
    // Last grant was A here; a lone B keeps alternation honest
    b_valid = 1; b_addr = 13; b_data = 32'hD;
    step();
    b_valid = 0;
    chk("lone_b_waddr", rf_waddr, 13);

    // Contention on the same address: A,B,A,B with no lost write
    a_valid = 1; a_addr = 3; a_data = 32'hA3;
    b_valid = 1; b_addr = 3; b_data = 32'hB3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_a_ready", i), a_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_b_ready", i), b_ready, (i % 2 == 0) ? 0 : 1);
      step();
      chk($sformatf("rr%0d_we", i), rf_we, 1);
      chk($sformatf("rr%0d_wdata", i), rf_wdata, (i % 2 == 0) ? 32'hA3 : 32'hB3);
    end
    a_valid = 0; b_valid = 0;

    // Mid-cycle reset clears write port and scoreboard, restores A priority
    iss_valid = 1; iss_addr = 4; rs1_addr = 4;
    a_valid = 1; a_addr = 10; a_data = 32'h10;
    step();
    iss_valid = 0; a_valid = 0;
    chk("pre_rst_busy4", rs1_busy, 1);
    chk("pre_rst_we", rf_we, 1);
    #2;
    rst = 1'b1;
    a_valid = 1; b_valid = 1; a_addr = 20; a_data = 32'h20; b_addr = 21; b_data = 32'h21;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_busy4", rs1_busy, 0);
    chk("arst_waddr", rf_waddr, 0);
    chk("arst_wdata", rf_wdata, 0);
    chk("arst_a_ready", a_ready, 0);
    chk("arst_b_ready", b_ready, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 0);
    step();
    a_valid = 0; b_valid = 0;
    chk("post_rst_waddr", rf_waddr, 20);
    chk("post_rst_wdata", rf_wdata, 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, register/data width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: a_valid  input  1  ALU writeback request.
REQ-005 SHALL have port: a_addr  input  5  ALU destination register.
REQ-006 SHALL have port: a_data  input  XLEN  ALU result.
REQ-007 SHALL have port: a_ready  output  1  ALU request accepted this cycle.
REQ-008 SHALL have port: b_valid  input  1  load-unit writeback request.
REQ-009 SHALL have port: b_addr  input  5  load destination register.
REQ-010 SHALL have port: b_data  input  XLEN  load result.
REQ-011 SHALL have port: b_ready  output  1  load request accepted this cycle.
REQ-012 SHALL have port: iss_valid  input  1  instruction issued with a destination register.
REQ-013 SHALL have port: iss_addr  input  5  destination of the issued instruction.
REQ-014 SHALL have port: rs1_addr  input  5  first source register to check.
REQ-015 SHALL have port: rs2_addr  input  5  second source register to check.
REQ-016 SHALL have port: rs1_busy  output  1  rs1_addr has a pending write.
REQ-017 SHALL have port: rs2_busy  output  1  rs2_addr has a pending write.
REQ-018 SHALL have port: rf_we  output  1  register-file write enable.
REQ-019 SHALL have port: rf_waddr  output  5  register-file write address.
REQ-020 SHALL have port: rf_wdata  output  XLEN  register-file write data.

Function
REQ-021 SHALL treat a handshake on a requester as valid&ready in the same cycle.
REQ-022 SHALL assert at most one of a_ready/b_ready per cycle.
REQ-023 SHALL drive ready from a_valid, b_valid and arbiter state only (combinational); ready SHALL be 0 when the matching valid is 0.
REQ-024 SHALL hold a 1-bit arbiter state, LAST_A or LAST_B, naming the last granted requester.
REQ-025 SHALL grant the only valid requester when exactly one is valid.
REQ-026 SHALL grant B in state LAST_A and A in state LAST_B when both are valid.
REQ-027 SHALL update the arbiter state to the granted side on every handshake and hold it otherwise.
REQ-028 SHALL register the accepted request: a handshake in cycle N gives rf_we=1 with that addr/data in cycle N+1 (one-cycle latency).
REQ-029 SHALL drive rf_we=0 in any cycle after a cycle with no handshake; rf_waddr/rf_wdata SHALL hold their last values.
REQ-030 SHALL accept a handshake to address 0 normally but SHALL leave rf_we=0 for it (x0 writes dropped).
REQ-031 SHALL keep a 32-entry busy scoreboard; entry 0 SHALL always read 0.
REQ-032 SHALL set busy[iss_addr] at the clock edge when iss_valid=1 and iss_addr!=0.
REQ-033 SHALL clear busy[addr] at the clock edge of a handshake to addr!=0.
REQ-034 SHALL let set win when a set and a clear hit the same address in one cycle.
REQ-035 SHALL drive rs1_busy=busy[rs1_addr] and rs2_busy=busy[rs2_addr] combinationally from the registered scoreboard, with no same-cycle bypass.
REQ-036 SHALL let the losing requester wait with no data loss when A and B target the same address in one cycle; the loser is granted on a later cycle.
REQ-037 SHALL ignore a clear for an address that is not busy.

Reset
REQ-038 SHALL immediately set rf_we=0, rf_waddr=0, rf_wdata=0, clear all busy bits and set state LAST_B while rst=1, regardless of clk.
REQ-039 SHALL drive a_ready=b_ready=0 while rst=1.
REQ-040 SHALL drop any in-flight request or pending write when reset is asserted mid-operation; the first grant after reset SHALL go to A when both are valid.

Verification
REQ-041 SHALL cover: after reset, a_valid=1 a_addr=5 a_data=0x11 and b_valid=1 b_addr=6 b_data=0x22 held -> cycle 0 grants A, cycle 1 gives rf_we=1 rf_waddr=5 rf_wdata=0x11 and grants B, cycle 2 gives rf_waddr=6 rf_wdata=0x22.
REQ-042 SHALL cover: iss_valid=1 iss_addr=7, then rs1_addr=7 -> rs1_busy=1 the next cycle; a_valid addr=7 handshake -> rs1_busy=0 the following cycle.
REQ-043 SHALL cover: a_valid a_addr=0 a_data=0xFF -> a_ready=1 and rf_we stays 0 the next cycle.
REQ-044 SHALL cover: iss_valid=1 iss_addr=9 in the same cycle as a handshake to addr 9 (busy[9]=1 beforehand) -> busy[9]=1 afterwards.
REQ-045 SHALL cover: both requesters valid to addr 3 continuously for 4 cycles -> grants alternate A,B,A,B and rf_we=1 on each of the following cycles.
REQ-046 SHALL cover: rst pulsed between clock edges with busy[4]=1 and rf_we=1 -> rf_we=0 and busy[4]=0 immediately; the next tie is granted to A.
